// File: rtl/fetch_pc.sv
// Fetch-stage PC unit: owns the F-stage PC, computes D-stage redirect
// targets, and runs a single-outstanding request/valid fetch from IMEM.
module fetch_pc #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] IMEM_BASE  = 32'h0000_3000,
  parameter logic [31:0] IMEM_LIMIT = 32'h0000_6FFC
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall_D,
  input  logic [3:0]  next_op_D,
  input  logic [31:0] pc_D,
  input  logic [15:0] imm16_D,
  input  logic [25:0] instr_index_D,
  input  logic [31:0] rs_fwd_D,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_F,
  output logic [31:0] instr_F,
  output logic        valid_F,
  output logic        exc_adel_F
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HAVE} state_t;

  state_t             state_q;
  state_t             state_d;
  logic               pend_v;
  logic [31:0]        pend_tgt;
  logic signed [31:0] br_off;
  logic [31:0]        target;
  logic               redirect_now;
  logic               accept;
  logic [31:0]        next_pc;
  logic               pc_legal;

  // Word-aligned and inside the instruction memory window.
  function automatic logic addr_legal(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a >= IMEM_BASE) && (a <= IMEM_LIMIT);
  endfunction

  assign br_off = {{14{imm16_D[15]}}, imm16_D, 2'b00};

  // Redirect target selected by the comparator code; codes 4-15 act as sequential.
  always_comb begin
    target = 32'h0;
    case (next_op_D)
      4'd1:    target = pc_D + 32'd4 + $unsigned(br_off);
      4'd2:    target = {pc_D[31:28], instr_index_D, 2'b00};
      4'd3:    target = rs_fwd_D;
      default: target = 32'h0;
    endcase
  end

  // A control transfer counts only once it actually leaves D; the delay slot
  // is whatever F hands over next, so a redirect not coincident with accept
  // is parked in pend until the delay slot is taken.
  assign redirect_now = ((next_op_D == 4'd1) || (next_op_D == 4'd2) ||
                         (next_op_D == 4'd3)) && !stall_D;
  assign accept       = valid_F && !stall_D;
  assign next_pc      = redirect_now ? target :
                        pend_v       ? pend_tgt : (pc_F + 32'd4);
  assign pc_legal     = addr_legal(pc_F);
  assign imem_addr    = pc_F;

  // Fetch FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state and request strobe; illegal PCs skip memory entirely.
  always_comb begin
    state_d  = state_q;
    imem_req = 1'b0;
    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (pc_legal) begin
          imem_req = 1'b1;
          state_d  = WAIT;
        end else begin
          state_d  = HAVE;
        end
      end
      WAIT: if (imem_rvalid) state_d = HAVE;
      HAVE: if (accept) state_d = REQ;
      default: state_d = IDLE;
    endcase
  end

  // F-stage PC, presented instruction and fault flag; rvalid outside WAIT is dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_F       <= RESET_PC;
      instr_F    <= 32'h0;
      exc_adel_F <= 1'b0;
      valid_F    <= 1'b0;
    end else begin
      if ((state_q == REQ) && !pc_legal) begin
        instr_F    <= 32'h0;
        exc_adel_F <= 1'b1;
        valid_F    <= 1'b1;
      end else if ((state_q == WAIT) && imem_rvalid) begin
        instr_F    <= imem_rdata;
        exc_adel_F <= 1'b0;
        valid_F    <= 1'b1;
      end else if ((state_q == HAVE) && accept) begin
        pc_F    <= next_pc;
        valid_F <= 1'b0;
      end
    end
  end

  // Pending redirect captured while the delay slot is still in F.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_v   <= 1'b0;
      pend_tgt <= 32'h0;
    end else if (accept) begin
      pend_v   <= 1'b0;
    end else if (redirect_now) begin
      pend_v   <= 1'b1;
      pend_tgt <= target;
    end
  end

endmodule

// File: tb/tb_fetch_pc.sv
// Randomized scoreboard bench for fetch_pc with a program-order fetch model.
module tb_fetch_pc;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] BASE     = 32'h0000_3000;
  localparam logic [31:0] LIMIT    = 32'h0000_6FFC;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        stall_D = 1'b0;
  logic [3:0]  next_op_D = 4'd0;
  logic [31:0] pc_D = 32'h0;
  logic [15:0] imm16_D = 16'h0;
  logic [25:0] instr_index_D = 26'h0;
  logic [31:0] rs_fwd_D = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] pc_F;
  logic [31:0] instr_F;
  logic        valid_F;
  logic        exc_adel_F;

  fetch_pc dut (
    .clk(clk), .reset_n(reset_n), .stall_D(stall_D), .next_op_D(next_op_D),
    .pc_D(pc_D), .imm16_D(imm16_D), .instr_index_D(instr_index_D),
    .rs_fwd_D(rs_fwd_D), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .pc_F(pc_F),
    .instr_F(instr_F), .valid_F(valid_F), .exc_adel_F(exc_adel_F)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        exc;
  } item_t;

  item_t       exp_q[$];
  logic [31:0] req_q[$];
  int          errors = 0;
  int          checks = 0;
  int          accepts = 0;
  int          acc_cyc = 0;
  bit          mon_en = 1'b0;
  bit          mem_en = 1'b1;
  logic [31:0] model_pc;
  bit          model_pend = 1'b0;
  logic [31:0] model_ptgt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit legal(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a >= BASE) && (a <= LIMIT);
  endfunction

  // Architectural target: what the program would jump to.
  function automatic logic [31:0] ref_target(input logic [3:0] op, input logic [31:0] pc,
                                             input logic [15:0] imm, input logic [25:0] idx,
                                             input logic [31:0] rs);
    int off;
    off = int'($signed(imm)) * 4;
    case (op)
      4'd1:    return pc + 32'd4 + 32'(off);
      4'd2:    return (pc & 32'hF000_0000) | (32'(idx) * 32'd4);
      4'd3:    return rs;
      default: return 32'h0;
    endcase
  endfunction

  // Expected delivery (and memory request, if the address is fetchable).
  task automatic push_fetch(input logic [31:0] a);
    item_t it;
    it.pc    = a;
    it.exc   = !legal(a);
    it.instr = legal(a) ? (32'h1111_0000 + a) : 32'h0;
    exp_q.push_back(it);
    if (legal(a)) req_q.push_back(a);
  endtask

  // Program-order model, evaluated once per cycle after inputs settle.
  task automatic model_step();
    bit redir;
    bit acc;
    logic [31:0] tgt;
    logic [31:0] nxt;
    redir = (next_op_D >= 4'd1) && (next_op_D <= 4'd3) && !stall_D;
    acc   = valid_F && !stall_D;
    tgt   = ref_target(next_op_D, pc_D, imm16_D, instr_index_D, rs_fwd_D);
    if (acc) begin
      nxt        = redir ? tgt : (model_pend ? model_ptgt : model_pc + 32'd4);
      model_pend = 1'b0;
      model_pc   = nxt;
      push_fetch(nxt);
      accepts++;
      acc_cyc    = cyc;
    end else if (redir) begin
      model_pend = 1'b1;
      model_ptgt = tgt;
    end
  endtask

  task automatic drive_random(input bit quiet);
    int r;
    if (quiet) begin
      stall_D   = 1'b0;
      next_op_D = 4'd0;
      return;
    end
    stall_D = ($urandom_range(0, 3) == 0);
    r = $urandom_range(0, 9);
    if (r < 6)       next_op_D = 4'd0;
    else if (r == 6) next_op_D = 4'($urandom_range(4, 15));
    else             next_op_D = 4'(r - 6);
    pc_D = ($urandom_range(0, 9) == 0) ? ($urandom & 32'hFFFF_FFFC)
                                       : (32'h3000 + 32'd4 * $urandom_range(0, 32'hFFF));
    imm16_D = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 127) - 64);
    instr_index_D = 26'($urandom_range(32'hB80, 32'h1C40));
    case ($urandom_range(0, 5))
      0: rs_fwd_D = 32'h3000 + 32'd4 * $urandom_range(0, 32'hFFF);
      1: rs_fwd_D = 32'h3000 + 32'd4 * $urandom_range(0, 32'hFFF) + $urandom_range(1, 3);
      2: rs_fwd_D = 32'h0000_7000;
      3: rs_fwd_D = 32'h0000_2FFC;
      4: rs_fwd_D = 32'h0000_6FFC;
      default: rs_fwd_D = $urandom;
    endcase
  endtask

  // Memory: answers each request after 1-3 cycles with 0x1111_0000+addr.
  initial begin
    logic [31:0] a;
    int lat;
    forever begin
      @(negedge clk);
      if (mem_en && reset_n && imem_req) begin
        a   = imem_addr;
        lat = $urandom_range(1, 3);
        repeat (lat) @(posedge clk);
        #1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h1111_0000 + a;
        @(posedge clk);
        #1;
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
      end
    end
  end

  // Monitor: compares F outputs and requests against the scoreboard queues.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && reset_n) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard: no expected fetch pending, pc_F=%h", pc_F);
        end else begin
          check("pc_F", pc_F, exp_q[0].pc);
          if (valid_F) begin
            check("instr_F", instr_F, exp_q[0].instr);
            check("exc_adel_F", 32'(exc_adel_F), 32'(exp_q[0].exc));
          end
        end
        if (imem_req) begin
          if (req_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_req: got addr %h expected no request", imem_addr);
          end else begin
            check("imem_addr", imem_addr, req_q.pop_front());
            check("req_latency", 32'(cyc), 32'(acc_cyc + 1));
          end
        end
        if (valid_F && !stall_D && (exp_q.size() > 0)) void'(exp_q.pop_front());
      end
    end
  end

  task automatic check_reset_values(input string tag);
    check({tag, "_pc_F"}, pc_F, RESET_PC);
    check({tag, "_valid_F"}, 32'(valid_F), 32'd0);
    check({tag, "_instr_F"}, instr_F, 32'h0);
    check({tag, "_exc_adel_F"}, 32'(exc_adel_F), 32'd0);
    check({tag, "_imem_req"}, 32'(imem_req), 32'd0);
    check({tag, "_imem_addr"}, imem_addr, RESET_PC);
  endtask

  task automatic release_reset();
    reset_n    = 1'b1;
    model_pc   = RESET_PC;
    model_pend = 1'b0;
    push_fetch(RESET_PC);
    acc_cyc    = cyc;
    mon_en     = 1'b1;
  endtask

  task automatic run_random(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      drive_random(i < 20);
      model_step();
    end
  endtask

  initial begin
    int n;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("por");
    @(posedge clk);
    #1;
    release_reset();
    run_random(3000);

    // Bring F to HAVE with the pipeline stalled.
    n = 0;
    do begin
      @(posedge clk);
      #1;
      stall_D   = 1'b1;
      next_op_D = 4'd0;
      model_step();
      n++;
    end while (!valid_F && n < 60);
    if (!valid_F) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: valid_F=%b expected 1 within 60 cycles", valid_F);
    end
    mem_en = 1'b0;
    // Accept with a jr to a legal target so the next fetch waits on memory.
    @(posedge clk);
    #1;
    stall_D   = 1'b0;
    next_op_D = 4'd3;
    rs_fwd_D  = 32'h0000_5000;
    model_step();
    @(posedge clk);
    #1;
    stall_D   = 1'b1;
    next_op_D = 4'd0;
    model_step();
    @(posedge clk);
    #1;
    model_step();
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    mon_en  = 1'b0;
    #1;
    check_reset_values("mid_wait");
    exp_q.delete();
    req_q.delete();
    repeat (2) @(posedge clk);
    #1;
    release_reset();
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    imem_rvalid = 1'b0;
    mem_en      = 1'b1;
    model_step();
    run_random(800);

    checks++;
    if (accepts < 200) begin
      errors++;
      $display("FAIL progress: got %0d accepts expected at least 200", accepts);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_pc.md
Name: fetch_pc

Overview:
- Fetch-stage PC unit, directly downstream of the D-stage branch comparator.
- Consumes the comparator's 4-bit next-PC code plus D-stage operands, computes the redirect target and owns the F-stage PC register.
- Runs a request/valid handshake with instruction memory and presents one instruction at a time to the F/D pipeline register.
- Architectural branch delay slot: the instruction at pc_D+4 always executes.

Parameters:
- RESET_PC, 32'h0000_3000, first fetch address after reset.
- IMEM_BASE, 32'h0000_3000, lowest legal fetch address.
- IMEM_LIMIT, 32'h0000_6FFC, highest legal fetch address (inclusive).

Ports:
- clk  in  1  single clock for the block; all state updates on rising edge.
- reset_n  in  1  reset, asynchronous, active-low.
- stall_D  in  1  hazard-unit stall; when 1, F/D does not accept and D holds.
- next_op_D  in  4  comparator code: 0 sequential, 1 branch taken, 2 jal, 3 jr; 4–15 treated as 0.
- pc_D  in  32  PC of the instruction currently in D.
- imm16_D  in  16  branch offset field.
- instr_index_D  in  26  jal target field.
- rs_fwd_D  in  32  forwarded rs value; jr target.
- imem_req  out  1  request strobe, asserted exactly one cycle per fetch.
- imem_addr  out  32  fetch address; valid while imem_req=1.
- imem_rvalid  in  1  read-data valid; arrives no earlier than the cycle after imem_req.
- imem_rdata  in  32  instruction word.
- pc_F  out  32  PC of the instruction presented or being fetched.
- instr_F  out  32  fetched instruction; 0 (nop) when faulted.
- valid_F  out  1  instr_F/pc_F/exc_adel_F valid for F/D.
- exc_adel_F  out  1  fetch address error: misaligned or outside [IMEM_BASE, IMEM_LIMIT].

Behaviour:
- Reset (async, reset_n=0):
  - pc_F=RESET_PC, state=IDLE.
  - valid_F=0, instr_F=0, exc_adel_F=0, pend_v=0, pend_tgt=0.
  - imem_req=0, imem_addr=pc_F.
- Redirect target (combinational from D inputs):
  - Code 1: pc_D + 4 + (sign_extend(imm16_D) << 2), modulo 2^32.
  - Code 2: {pc_D[31:28], instr_index_D, 2'b00}.
  - Code 3: rs_fwd_D.
- redirect_now = (next_op_D in {1,2,3}) && !stall_D, i.e. the control-transfer instruction leaves D this cycle.
- accept = valid_F && !stall_D.
- Next PC on accept:
  - redirect_now → target;
  - else pend_v → pend_tgt;
  - else pc_F+4.
  - pend_v clears on accept.
- redirect_now && !accept: the delay slot is not yet accepted; pend_v=1, pend_tgt=target.
- Delay-slot instruction is never squashed. This block has no flush input.
- FSM:
  - IDLE: unconditionally → REQ next cycle.
  - REQ:
    - If pc_F is legal: imem_req=1, imem_addr=pc_F, → WAIT.
    - If pc_F is illegal (pc_F[1:0]!=0 or out of range): no request; instr_F=0, exc_adel_F=1, valid_F=1, → HAVE.
  - WAIT: on imem_rvalid, instr_F=imem_rdata, exc_adel_F=0, valid_F=1 (registered, visible next cycle), → HAVE. Otherwise stay.
  - HAVE: valid_F=1. On accept: pc_F=next PC, valid_F=0, → REQ. Otherwise hold all outputs stable.
- imem_rvalid outside WAIT is ignored. This covers a stale response arriving after reset.
- Latency: accept at t → imem_req at t+1 → rvalid earliest t+2 → valid_F at t+3.
- At most one outstanding memory request.
- pc_F changes only on accept or reset.
- Reset mid-WAIT aborts the fetch. Its late rvalid is dropped; the bench must observe the first request at RESET_PC after release.

Test Plan:
1. Reset release, 1-cycle memory returning 0x1111_0000+addr, stall_D=0, next_op_D=0 → requests to 0x3000, 0x3004, 0x3008, one per 3 cycles; instr_F matches.
2. beq: pc_D=0x3004, imm16_D=0x0003, next_op_D=1 in the cycle the delay slot 0x3008 is accepted → next imem_addr=0x3014; 0x3008 still delivered once.
3. Backward branch: pc_D=0x3010, imm16_D=0xFFFF, next_op_D=1 while F is in WAIT for 0x3014 → pend_v=1; after 0x3014 is accepted, imem_addr=0x3010.
4. jal: pc_D=0x3020, instr_index_D=0x0000C10 → target 0x0000_3040. jr with rs_fwd_D=0x0000_3002 → no imem_req, valid_F=1, exc_adel_F=1, instr_F=0. jr with rs_fwd_D=0x0000_7000 → same result.
5. stall_D=1 for 5 cycles in HAVE with next_op_D=1 → no redirect and no pend_v set; pc_F, instr_F, valid_F stable. Release → normal accept.
6. Assert reset_n=0 mid-WAIT, then pulse imem_rvalid after release before the new request → stale data ignored; first imem_req is at 0x3000.
